bsg_credit_to_token_decimator: RTL
==================================

# bsg_credit_to_token_decimator

Write-domain stage that feeds the `w_inc_token_i` input of the asynchronous credit counter. It accumulates per-item credit returns and compresses every 2^`lg_credit_to_token_decimation_p` credits into one token pulse. Whole tokens are buffered in a small pending counter while the downstream launch point is not ready. All logic is in one clock domain; the clock-domain crossing happens downstream of this block.

## Interface
Parameters:
- `lg_credit_to_token_decimation_p`, default 4, log2 of credits per token (16 by default); legal range is 1 to 16.
- `max_pending_tokens_p`, default 4, maximum number of whole tokens held while `ready_i` is low; must be at least 1.

Ports:
- `clk_i`  in  1  clock. All state updates on the rising edge.
- `reset_i`  in  1  reset; synchronous, active-high.
- `credit_i`  in  1  one credit returned this cycle.
- `ready_i`  in  1  downstream can accept a token this cycle.
- `token_o`  out  1  one-cycle token pulse. Drive it straight into `w_inc_token_i`.
- `credits_r_o`  out  `lg_credit_to_token_decimation_p`  partial credit count.
- `pending_tokens_r_o`  out  `$clog2(max_pending_tokens_p+1)`  whole tokens not yet emitted.
- `overflow_r_o`  out  1  sticky flag: a token was dropped because the pending counter was full.

## Operation
- **Reset values.** While `reset_i` is high, at each edge: `credits_r_o` = 0, `pending_tokens_r_o` = 0, `overflow_r_o` = 0. `token_o` = 0 because pending is 0.
- **Credit counter.**
  - It is a modulo-2^lg counter that increments by 1 on each cycle with `credit_i` = 1.
  - A token is formed (`tok_make`) when `credit_i` = 1 and `credits_r_o` = 2^lg − 1.
  - On `tok_make` the counter wraps to 0; it never saturates.
- **Token emission.**
  - `token_o` = `ready_i` & (`pending_tokens_r_o` != 0).
  - `token_o` is combinational from the register and `ready_i`. It has no dependence on `credit_i`.
  - At most one token is emitted per cycle.
- **Pending counter update**, per cycle:
  - `tok_make` and `token_o` both true: unchanged.
  - `tok_make` only: +1, unless the counter equals `max_pending_tokens_p`. In that case it holds, the token is discarded, and `overflow_r_o` sets to 1.
  - `token_o` only: −1.
  - Neither: hold.
- **Overflow flag.** `overflow_r_o` clears only on reset.
- **Credits while full.** The credit counter keeps counting while pending is full. Only whole tokens are lost.
- **Reset mid-operation.** A partial credit count is discarded, and so are pending tokens. No `token_o` is emitted in the reset cycle or in the cycle after it.
- **Assertions.** Simulation-only assertions check:
  - `credit_i` is not X when out of reset;
  - `pending_tokens_r_o` ≤ `max_pending_tokens_p`.

## Timing
- **Credit-to-token latency.** The credit that completes a group arrives at edge t. `pending_tokens_r_o` reflects it after edge t. `token_o` can assert in cycle t+1 at the earliest, provided `ready_i` = 1. The minimum latency is therefore 1 cycle.
- **Back-to-back tokens.** With `ready_i` held high, pending tokens drain at one per cycle.
- **Throughput.** A steady stream of one credit per cycle yields one token every 2^lg cycles, with no loss, for any `max_pending_tokens_p` ≥ 1.
- **Ready handshake.** `ready_i` may toggle in any cycle. A token counts as delivered only in a cycle where `token_o` = 1. There is no hold requirement on the token when `ready_i` is low.
- **Register placement.** All outputs except `token_o` come directly from registers.

## Test plan
All scenarios use default parameters.
1. **Single token.** Reset, then `ready_i` = 1 and 16 consecutive `credit_i` pulses at cycles 0–15 → `token_o` = 1 only in cycle 16; `credits_r_o` = 0 and `pending_tokens_r_o` = 0 after cycle 16.
2. **Buffering and drain.** `ready_i` = 0 and 64 credits → `pending_tokens_r_o` = 4 and no `token_o`. Then `ready_i` = 1 → `token_o` high for exactly 4 consecutive cycles, then pending = 0; `overflow_r_o` = 0 throughout.
3. **Overflow.** `ready_i` = 0 and 80 credits → pending = 4, `credits_r_o` = 0, `overflow_r_o` = 1 from the cycle after credit 80. Then raise `ready_i` → exactly 4 tokens; `overflow_r_o` stays 1.
4. **Simultaneous make and emit.**
   - Set up pending = 1 with `ready_i` = 0 (16 credits), then 15 more credits.
   - In one cycle drive `ready_i` = 1 together with credit 32 → `token_o` = 1 in that cycle and pending stays 1.
   - `token_o` = 1 again in the next cycle; pending = 0 after it.
5. **Reset mid-operation.** 10 credits, then a 1-cycle `reset_i` → all outputs 0. The next 16 credits with `ready_i` = 1 produce exactly one token, in the cycle after credit 16.
6. **Random soak.** Random `credit_i` and `ready_i` for 10,000 cycles, checked against a scoreboard:
   - total tokens emitted + tokens dropped + pending = floor(total credits / 16);
   - the drop count is nonzero only if `overflow_r_o` = 1.

Source files
------------

// File: rtl/bsg_credit_to_token_decimator.sv
// bsg_credit_to_token_decimator: compresses 2^lg credit returns into buffered one-cycle token pulses
module bsg_credit_to_token_decimator #(
  parameter int lg_credit_to_token_decimation_p = 4,
  parameter int max_pending_tokens_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic credit_i,
  input  logic ready_i,
  output logic token_o,
  output logic [lg_credit_to_token_decimation_p-1:0] credits_r_o,
  output logic [$clog2(max_pending_tokens_p+1)-1:0] pending_tokens_r_o,
  output logic overflow_r_o
);
  localparam int lg_lp = lg_credit_to_token_decimation_p;
  localparam int pw_lp = $clog2(max_pending_tokens_p+1);
  localparam logic [pw_lp-1:0] max_lp = pw_lp'(max_pending_tokens_p);
  logic [lg_lp-1:0] credits_q, credits_d;
  logic [pw_lp-1:0] pending_q, pending_d;
  logic overflow_q, overflow_d, tok_make, full, grow;
  // form tokens from wrapping credits, emit from the pending pool, drop whole tokens when full
  always_comb begin
    tok_make = credit_i & (&credits_q);
    token_o = ready_i & ~reset_i & (pending_q != '0);
    full = pending_q == max_lp;
    grow = tok_make & ~token_o;
    credits_d = credits_q + lg_lp'(credit_i);
    pending_d = (grow & ~full) ? pending_q + pw_lp'(1) : (token_o & ~tok_make) ? pending_q - pw_lp'(1) : pending_q;
    overflow_d = overflow_q | (grow & full);
  end
  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_q <= '0;
      pending_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      pending_q <= pending_d;
      overflow_q <= overflow_d;
    end
  end
  assign credits_r_o = credits_q;
  assign pending_tokens_r_o = pending_q;
  assign overflow_r_o = overflow_q;
`ifndef SYNTHESIS
  // simulation sanity checks on inputs and pending bound
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!$isunknown(credit_i)) else $error("credit_i is X out of reset");
      assert (pending_q <= max_lp) else $error("pending exceeds max_pending_tokens_p");
    end
  end
`endif
endmodule
